laser_frame_sched: RTL and testbench
====================================

# laser_frame_sched

Frame sequencer sitting between the host point stream and the two-circle LASER solver engine. It accepts 40-point frames from the host over a valid/ready handshake into a double-buffered point store. It parks the engine in reset between jobs, then releases it and replays a stored frame at one point per cycle. It waits for engine completion under a watchdog and returns the two circle centres to the host over a second valid/ready handshake.

## Interface
- NPTS, 40: points per frame; sets bank depth and feed length.
- TIMEOUT, 8191: maximum RUN cycles before a job is abandoned; watchdog counter is 13 bits.
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- IN_VALID  in  1  host point valid.
- IN_READY  out  1  point accepted when IN_VALID && IN_READY at an edge.
- IN_X, IN_Y  in  4 each  host point coordinates.
- ENG_HOLD  out  1  drives engine RST; high parks the engine.
- ENG_X, ENG_Y  out  4 each  point stream to engine X/Y.
- ENG_DONE  in  1  engine completion pulse; C1X..C2Y valid in the same cycle.
- ENG_C1X, ENG_C1Y, ENG_C2X, ENG_C2Y  in  4 each  engine results.
- RES_VALID  out  1  result slot occupied.
- RES_READY  in  1  host consumes the result when RES_VALID && RES_READY.
- RES_C1X, RES_C1Y, RES_C2X, RES_C2Y  out  4 each  captured centres.
- RES_TMO  out  1  result came from a watchdog expiry; coordinates are 0.

## Operation
- Point store: two banks of NPTS×8 bits, full[1:0], write bank wb, write index wi, read bank rb.
  - IN_READY = !full[wb].
  - On accept: bank[wb][wi] <= {IN_X, IN_Y} and wi increments.
  - At wi == NPTS-1: full[wb] <= 1, wi <= 0, wb toggles.
- FSM states: PARK, ARM, FEED, RUN, CAP.
  - PARK: ENG_HOLD=1. Go to ARM when full[rb] && !RES_VALID.
  - ARM: ENG_HOLD=0, lasts exactly 1 cycle. Go to FEED.
  - FEED: read index ri runs 0..NPTS-1, one per cycle. ENG_X/ENG_Y = bank[rb][ri], registered. Go to RUN after ri == NPTS-1.
  - RUN: the watchdog counts up from 0. ENG_DONE=1 goes to CAP (normal). Watchdog reaching TIMEOUT goes to CAP with the tmo flag set.
  - CAP, single cycle:
    - RES_C* <= ENG_C* (or 0 on tmo), RES_TMO <= tmo, RES_VALID <= 1.
    - full[rb] <= 0, rb toggles, ENG_HOLD <= 1. Go to PARK.
- ENG_DONE outside RUN is ignored.
- ENG_X/ENG_Y are 0 outside FEED.
- RES_VALID clears on the handshake. RES_* hold their value until the next CAP.
- Host fill of the other bank proceeds during FEED/RUN. A bank freed in CAP may be written starting the next cycle.
- Simultaneous last-point accept into bank X and CAP freeing bank Y: both updates apply; no conflict since X≠Y.

## Timing
- Reset values:
  - ENG_HOLD=1, IN_READY=1, RES_VALID=0, RES_TMO=0.
  - All RES_* and ENG_X/ENG_Y = 0.
  - State PARK; wb=rb=0; full=00.
- ENG_HOLD falls at the edge entering ARM. Point k appears on ENG_X/ENG_Y in the (k+2)-th cycle after ENG_HOLD falls, for k = 0..NPTS-1, with no gaps.
- Minimum PARK→PARK job length: 1 (ARM) + NPTS (FEED) + RUN + 1 (CAP).
- RES_VALID rises the cycle after ENG_DONE is sampled.
- Result backpressure: while RES_VALID=1, PARK does not launch. Host input continues until both banks are full, then IN_READY=0.
- RST mid-operation:
  - All state returns to reset values immediately.
  - Partially written or stored frames are discarded.
  - ENG_HOLD asserts asynchronously.

## Structure
- Shared package laser_pkg: NPTS, coordinate width (4), the FSM state enum, and the point struct {x, y}.
- Sub-module laser_pt_bank: single bank, one write port, one registered read port. Instantiated twice, keeping the sequencer at the pointer/FSM level.

## Test plan
- Single frame, behavioural engine model returning DONE 4800 cycles after feed start with centres (3,4),(12,11): ENG_X/ENG_Y replay 40 points in order starting 2 cycles after ENG_HOLD falls; RES_VALID=1 with (3,4,12,11), RES_TMO=0.
- Send 3 frames back-to-back with RES_READY=1: frame 1 accepted without IN_READY dropping during job 0; frame 2 stalls (IN_READY=0) until CAP of job 0; results return in order.
- Hold RES_READY=0 after job 0: job 1 does not launch (ENG_HOLD stays 1) until the handshake; RES_* stable throughout.
- Engine model never pulses DONE: CAP after 8191 RUN cycles; RES_TMO=1, coordinates 0; a later stray DONE is ignored.
- Assert RST at FEED point 17: ENG_HOLD=1 and IN_READY=1 immediately, full=00; the next full frame runs normally.
- Last host point of bank 1 accepted in the same cycle as CAP of bank 0: full goes 01→10 correctly; the next launch uses bank 1.

Source files
------------

// File: rtl/laser_pkg.sv
// Shared constants and types for the LASER frame sequencer and its point store.
package laser_pkg;

    localparam int unsigned NPTS = 40;
    localparam int unsigned CW   = 4;

    typedef logic [2:0] state_t;

    localparam state_t ST_PARK = 3'd0;
    localparam state_t ST_ARM  = 3'd1;
    localparam state_t ST_FEED = 3'd2;
    localparam state_t ST_RUN  = 3'd3;
    localparam state_t ST_CAP  = 3'd4;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
    } pt_t;

endpackage

// File: rtl/laser_pt_bank.sv
// One frame bank of the point store: a write port and a registered read port
// whose output returns to zero whenever no read is requested.
module laser_pt_bank
    import laser_pkg::*;
#(
    parameter int unsigned DEPTH = NPTS,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [2*CW-1:0] wdata,
    input  logic            rd_en,
    input  logic [AW-1:0]   raddr,
    output logic [2*CW-1:0] rdata
);

    logic [2*CW-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= mem[raddr];
        end else begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/laser_frame_sched.sv
// Frame sequencer: double-buffered host point store, engine park/feed/run
// control with a watchdog, and a single-slot result buffer toward the host.
module laser_frame_sched
    import laser_pkg::*;
#(
    parameter int unsigned NPTS    = laser_pkg::NPTS,
    parameter int unsigned TIMEOUT = 8191
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [CW-1:0] IN_X,
    input  logic [CW-1:0] IN_Y,
    output logic          ENG_HOLD,
    output logic [CW-1:0] ENG_X,
    output logic [CW-1:0] ENG_Y,
    input  logic          ENG_DONE,
    input  logic [CW-1:0] ENG_C1X,
    input  logic [CW-1:0] ENG_C1Y,
    input  logic [CW-1:0] ENG_C2X,
    input  logic [CW-1:0] ENG_C2Y,
    output logic          RES_VALID,
    input  logic          RES_READY,
    output logic [CW-1:0] RES_C1X,
    output logic [CW-1:0] RES_C1Y,
    output logic [CW-1:0] RES_C2X,
    output logic [CW-1:0] RES_C2Y,
    output logic          RES_TMO
);

    localparam int unsigned   AW       = $clog2(NPTS);
    localparam logic [AW-1:0] LAST_IDX = AW'(NPTS - 1);
    localparam logic [12:0]   WD_LAST  = 13'(TIMEOUT - 1);

    state_t          st;
    logic [1:0]      full;
    logic            wb;
    logic            rb;
    logic [AW-1:0]   wi;
    logic [AW-1:0]   ri;
    logic [12:0]     wd;
    logic            hold;
    logic            tmo;
    logic [4*CW-1:0] cap;
    pt_t             wpt;
    pt_t             rpt;
    logic [2*CW-1:0] rd0;
    logic [2*CW-1:0] rd1;
    logic            acc;
    logic            wlast;
    logic            feed;

    assign IN_READY = !full[wb];
    assign acc      = IN_VALID && IN_READY;
    assign wlast    = acc && (wi == LAST_IDX);
    assign feed     = (st == ST_FEED);
    assign wpt      = '{x: IN_X, y: IN_Y};
    assign rpt      = rd0 | rd1;
    assign ENG_X    = rpt.x;
    assign ENG_Y    = rpt.y;
    assign ENG_HOLD = hold;

    laser_pt_bank #(.DEPTH(NPTS)) u_bank0 (
        .CLK   (CLK),
        .RST   (RST),
        .we    (acc && !wb),
        .waddr (wi),
        .wdata (wpt),
        .rd_en (feed && !rb),
        .raddr (ri),
        .rdata (rd0)
    );

    laser_pt_bank #(.DEPTH(NPTS)) u_bank1 (
        .CLK   (CLK),
        .RST   (RST),
        .we    (acc && wb),
        .waddr (wi),
        .wdata (wpt),
        .rd_en (feed && rb),
        .raddr (ri),
        .rdata (rd1)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wb <= 1'b0;
            wi <= '0;
        end else if (acc) begin
            if (wi == LAST_IDX) begin
                wi <= '0;
                wb <= ~wb;
            end else begin
                wi <= wi + 1'b1;
            end
        end
    end

    // CAP only frees rb and the host only fills wb while it is empty, so a
    // completing write and a CAP release can never target the same bank.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            full <= '0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (st == ST_CAP && rb == 1'(i)) begin
                    full[i] <= 1'b0;
                end else if (wlast && wb == 1'(i)) begin
                    full[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            st        <= ST_PARK;
            rb        <= 1'b0;
            ri        <= '0;
            wd        <= '0;
            hold      <= 1'b1;
            tmo       <= 1'b0;
            cap       <= '0;
            RES_VALID <= 1'b0;
            RES_TMO   <= 1'b0;
            RES_C1X   <= '0;
            RES_C1Y   <= '0;
            RES_C2X   <= '0;
            RES_C2Y   <= '0;
        end else begin
            if (RES_VALID && RES_READY) begin
                RES_VALID <= 1'b0;
            end
            case (st)
                ST_PARK: begin
                    if (full[rb] && !RES_VALID) begin
                        st   <= ST_ARM;
                        hold <= 1'b0;
                    end
                end
                ST_ARM: begin
                    st <= ST_FEED;
                    ri <= '0;
                end
                ST_FEED: begin
                    if (ri == LAST_IDX) begin
                        st <= ST_RUN;
                        ri <= '0;
                        wd <= '0;
                    end else begin
                        ri <= ri + 1'b1;
                    end
                end
                ST_RUN: begin
                    // Centres are only valid alongside DONE, so latch them here.
                    if (ENG_DONE) begin
                        cap <= {ENG_C1X, ENG_C1Y, ENG_C2X, ENG_C2Y};
                        tmo <= 1'b0;
                        st  <= ST_CAP;
                    end else if (wd == WD_LAST) begin
                        cap <= '0;
                        tmo <= 1'b1;
                        st  <= ST_CAP;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                ST_CAP: begin
                    {RES_C1X, RES_C1Y, RES_C2X, RES_C2Y} <= cap;
                    RES_TMO   <= tmo;
                    RES_VALID <= 1'b1;
                    rb        <= ~rb;
                    hold      <= 1'b1;
                    st        <= ST_PARK;
                end
                default: begin
                    st   <= ST_PARK;
                    hold <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_laser_frame_sched.sv
// Bench for laser_frame_sched: host/engine/result-sink model running on the
// falling edge, with a frame-level reference of stored frames and results.
module tb_laser_frame_sched;

    localparam int NPTS    = 40;
    localparam int TIMEOUT = 8191;

    logic       CLK, RST;
    logic       IN_VALID, IN_READY;
    logic [3:0] IN_X, IN_Y;
    logic       ENG_HOLD;
    logic [3:0] ENG_X, ENG_Y;
    logic       ENG_DONE;
    logic [3:0] ENG_C1X, ENG_C1Y, ENG_C2X, ENG_C2Y;
    logic       RES_VALID, RES_READY;
    logic [3:0] RES_C1X, RES_C1Y, RES_C2X, RES_C2Y;
    logic       RES_TMO;

    laser_frame_sched #(.NPTS(NPTS), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST(RST),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_X(IN_X), .IN_Y(IN_Y),
        .ENG_HOLD(ENG_HOLD), .ENG_X(ENG_X), .ENG_Y(ENG_Y), .ENG_DONE(ENG_DONE),
        .ENG_C1X(ENG_C1X), .ENG_C1Y(ENG_C1Y), .ENG_C2X(ENG_C2X), .ENG_C2Y(ENG_C2Y),
        .RES_VALID(RES_VALID), .RES_READY(RES_READY),
        .RES_C1X(RES_C1X), .RES_C1Y(RES_C1Y), .RES_C2X(RES_C2X), .RES_C2Y(RES_C2Y),
        .RES_TMO(RES_TMO)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        int          done_at;
        logic [15:0] cen;
        bit          stray;
    } job_t;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  sendq[$];
    logic [7:0]  partial[$];
    logic [7:0]  stored[$];
    logic [7:0]  cur [NPTS];
    job_t        jobq[$];
    job_t        job;
    logic [16:0] res_exp[$];
    logic [16:0] last_res;
    int          n;
    bit          running, drv_valid, seen_ready, res_take, prev_hold, prev_can;
    bit          gaps = 1'b0;
    int          rr_mode = 0;
    int          jobs_done = 0;
    int          stall_cycles = 0;
    int          stray_cnt = 0;
    int          stray_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Host source, engine model, result sink and reference, all on negedge.
    initial begin : world
        logic [7:0]  tmp;
        logic [16:0] obs;
        int          end_n;
        forever begin
            @(negedge CLK);
            if (RST) begin
                sendq.delete(); partial.delete(); stored.delete();
                jobq.delete(); res_exp.delete();
                last_res = '0; running = 0; n = 0;
                drv_valid = 0; seen_ready = 0; res_take = 0;
                prev_hold = 1; prev_can = 0; stray_seen = stray_cnt;
                IN_VALID = 0; ENG_DONE = 0; RES_READY = 0;
            end else begin
                if (drv_valid && seen_ready) begin
                    partial.push_back(sendq.pop_front());
                    if (partial.size() == NPTS) begin
                        foreach (partial[i]) stored.push_back(partial[i]);
                        partial.delete();
                    end
                end
                if (res_take) last_res = res_exp.pop_front();
                if (prev_hold) check("launch_hold", ENG_HOLD, !prev_can);

                ENG_DONE = 1'b0;
                {ENG_C1X, ENG_C1Y, ENG_C2X, ENG_C2Y} = 16'($urandom);
                if (!ENG_HOLD) begin
                    if (!running) begin
                        running = 1; n = 0;
                        check("launch_frame", stored.size() >= NPTS && jobq.size() > 0, 1);
                        for (int i = 0; i < NPTS; i++) cur[i] = (i < stored.size()) ? stored[i] : 8'h00;
                        job = (jobq.size() > 0) ? jobq.pop_front() : '{-1, 16'h0, 1'b0};
                    end else begin
                        n++;
                    end
                    if (n >= 2 && n < NPTS + 2) check("eng_point", {ENG_X, ENG_Y}, cur[n-2]);
                    else check("eng_idle", {ENG_X, ENG_Y}, 8'h00);
                    if (job.done_at >= 0 && n == job.done_at) begin
                        ENG_DONE = 1'b1;
                        {ENG_C1X, ENG_C1Y, ENG_C2X, ENG_C2Y} = job.cen;
                    end
                    if (job.stray && n == 10) ENG_DONE = 1'b1;
                end else begin
                    if (running) begin
                        end_n = (job.done_at >= 0) ? job.done_at + 2 : NPTS + TIMEOUT + 2;
                        check("job_length", n + 1, end_n);
                        running = 0;
                        for (int i = 0; i < NPTS; i++) if (stored.size() > 0) tmp = stored.pop_front();
                        res_exp.push_back(job.done_at >= 0 ? {1'b0, job.cen} : 17'h10000);
                        jobs_done++;
                    end
                    check("eng_parked", {ENG_X, ENG_Y}, 8'h00);
                    if (stray_seen != stray_cnt) begin
                        ENG_DONE = 1'b1;
                        stray_seen = stray_cnt;
                    end
                end

                check("res_valid", RES_VALID, res_exp.size() > 0);
                obs = {RES_TMO, RES_C1X, RES_C1Y, RES_C2X, RES_C2Y};
                if (res_exp.size() > 0) check("res_data", obs, res_exp[0]);
                else check("res_hold", obs, last_res);
                check("in_ready", IN_READY, stored.size() < 2 * NPTS);

                prev_hold = ENG_HOLD;
                prev_can  = ENG_HOLD && stored.size() >= NPTS && !RES_VALID;

                drv_valid = sendq.size() > 0 && (!gaps || $urandom_range(0, 3) != 0);
                IN_VALID  = drv_valid;
                {IN_X, IN_Y} = drv_valid ? sendq[0] : 8'($urandom);
                seen_ready = IN_READY;
                if (drv_valid && !IN_READY) stall_cycles++;
                RES_READY = (rr_mode == 0) ? 1'b0 : (rr_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
                res_take  = RES_VALID && RES_READY;
            end
        end
    end

    task automatic push_frames(input int nf);
        for (int i = 0; i < nf * NPTS; i++) sendq.push_back(8'($urandom));
    endtask

    task automatic push_job(input int d, input logic [15:0] cen, input bit stray);
        job_t j;
        j.done_at = d; j.cen = cen; j.stray = stray;
        jobq.push_back(j);
    endtask

    task automatic wait_jobs(input int target, input int budget);
        int k = 0;
        while (jobs_done < target && k < budget) begin
            @(negedge CLK); #1; k++;
        end
        check("wait_jobs", jobs_done >= target, 1);
    endtask

    task automatic wait_res_empty(input int budget);
        int k = 0;
        while (res_exp.size() > 0 && k < budget) begin
            @(negedge CLK); #1; k++;
        end
        check("wait_res", res_exp.size(), 0);
    endtask

    task automatic wait_feed(input int at, input int budget);
        int k = 0;
        while (!(running && n == at) && k < budget) begin
            @(negedge CLK); #1; k++;
        end
        check("wait_feed", running && n == at, 1);
    endtask

    task automatic check_reset_outputs();
        check("rst_hold", ENG_HOLD, 1);
        check("rst_ready", IN_READY, 1);
        check("rst_res_valid", RES_VALID, 0);
        check("rst_res", {RES_TMO, RES_C1X, RES_C1Y, RES_C2X, RES_C2Y}, 0);
        check("rst_eng", {ENG_X, ENG_Y}, 0);
    endtask

    task automatic pulse_reset();
        @(posedge CLK); #2; RST = 1'b1;
        #1; check_reset_outputs();
        @(posedge CLK); #2; RST = 1'b0;
    endtask

    initial begin : main
        int base;
        RST = 1'b1; RES_READY = 1'b0; IN_VALID = 1'b0; ENG_DONE = 1'b0;
        IN_X = '0; IN_Y = '0;
        {ENG_C1X, ENG_C1Y, ENG_C2X, ENG_C2Y} = '0;
        repeat (2) @(negedge CLK);
        #1; check_reset_outputs();
        @(posedge CLK); #2; RST = 1'b0;

        // single long job with fixed centres
        rr_mode = 0; gaps = 0;
        push_job(4802, 16'h34CB, 0);
        push_frames(1);
        wait_jobs(1, 6000);
        check("t1_valid", RES_VALID, 1);
        check("t1_centres", {RES_C1X, RES_C1Y, RES_C2X, RES_C2Y}, 16'h34CB);
        check("t1_tmo", RES_TMO, 0);
        rr_mode = 1;
        wait_res_empty(20);

        // three back-to-back frames; the third must stall until job 0 frees a bank
        base = jobs_done;
        stall_cycles = 0;
        push_job(100, 16'h1234, 0);
        push_job(60, 16'h5678, 0);
        push_job(60, 16'h9ABC, 0);
        push_frames(3);
        wait_jobs(base + 3, 1000);
        check("t3_stalled", stall_cycles > 0, 1);
        wait_res_empty(20);

        // result backpressure blocks the next launch
        base = jobs_done;
        rr_mode = 0;
        push_job(50, 16'hA1B2, 0);
        push_job(50, 16'hC3D4, 0);
        push_frames(2);
        wait_jobs(base + 1, 500);
        repeat (200) @(negedge CLK);
        #1;
        check("t4_no_launch", jobs_done, base + 1);
        check("t4_parked", ENG_HOLD, 1);
        rr_mode = 1;
        wait_jobs(base + 2, 500);
        wait_res_empty(20);

        // watchdog expiry, then a stray DONE while parked
        base = jobs_done;
        rr_mode = 0;
        push_job(-1, 16'hFFFF, 0);
        push_frames(1);
        wait_jobs(base + 1, 9000);
        check("t5_tmo", RES_TMO, 1);
        check("t5_zero", {RES_C1X, RES_C1Y, RES_C2X, RES_C2Y}, 0);
        stray_cnt++;
        repeat (5) @(negedge CLK);
        #1;
        check("t5_stray_jobs", jobs_done, base + 1);
        check("t5_stray_tmo", {RES_VALID, RES_TMO}, 2'b11);
        rr_mode = 1;
        wait_res_empty(20);

        // reset while point 17 is on the engine bus, partial next frame discarded
        push_job(80, 16'h1111, 0);
        push_frames(1);
        for (int i = 0; i < 20; i++) sendq.push_back(8'($urandom));
        wait_feed(19, 300);
        pulse_reset();
        base = jobs_done;
        push_job(60, 16'h2468, 0);
        push_frames(1);
        wait_jobs(base + 1, 300);
        wait_res_empty(20);

        // last point of bank 1 lands on the same edge that CAP frees bank 0
        pulse_reset();
        base = jobs_done;
        push_job(100, 16'h7E57, 0);
        push_job(60, 16'hBEEF, 0);
        push_frames(1);
        for (int i = 0; i < NPTS - 1; i++) sendq.push_back(8'($urandom));
        wait_feed(100, 400);
        sendq.push_back(8'($urandom));
        wait_jobs(base + 1, 50);
        check("t7_ready", IN_READY, 1);
        wait_jobs(base + 2, 400);
        wait_res_empty(20);

        // randomized traffic: host gaps, random result acceptance, stray DONE in feed
        base = jobs_done;
        rr_mode = 2; gaps = 1;
        for (int i = 0; i < 6; i++)
            push_job(int'($urandom_range(41, 150)), 16'($urandom), 1'($urandom_range(0, 1)));
        push_frames(6);
        wait_jobs(base + 6, 4000);
        rr_mode = 1;
        wait_res_empty(50);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
